// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and FSM state type for the conv2 post-processing stage
package cnn_pkg;

  localparam int ACC_W = 20;
  localparam int SHIFT = 8;
  localparam int CH_N  = 32;
  localparam int Q_MAX = 127;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } pool_state_t;

endpackage

// File: rtl/conv2_quant.sv
// rtl/conv2_quant.sv - ReLU, optional round-half-up, right shift and saturate for one accumulator
// CONV2_POOL_ROUND_EN selects round-half-up; otherwise the shift truncates.
module conv2_quant
  import cnn_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output logic        [7:0]       q
);

`ifdef CONV2_POOL_ROUND_EN
  localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
`else
  localparam logic [ACC_W:0] RND = '0;
`endif

  logic [ACC_W:0] sum;
  logic [ACC_W:0] shifted;

  // One extra bit keeps acc + RND from wrapping; negative inputs never reach the shift result.
  always_comb begin
    sum     = {1'b0, acc} + RND;
    shifted = sum >> SHIFT;
    q       = '0;
    if (acc[ACC_W-1]) begin
      q = '0;
    end else if (shifted > (ACC_W + 1)'(Q_MAX)) begin
      q = 8'(Q_MAX);
    end else begin
      q = shifted[7:0];
    end
  end

endmodule

// File: rtl/conv2_pool.sv
// rtl/conv2_pool.sv - capture an 18x2 accumulator tile, 2x2 max-pool, requantize, stream bytes
// Rounding mode follows CONV2_POOL_ROUND_EN (handled inside conv2_quant).
module conv2_pool
  import cnn_pkg::*;
#(
  parameter int ROWS = 18,
  parameter int COLS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic [ROWS*COLS*ACC_W-1:0] data_in,
  output logic                       ready_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [7:0]                 data_o,
  output logic [3:0]                 row_o,
  output logic [4:0]                 ch_o,
  output logic                       last_o
);

  localparam int         NP       = ROWS / 2;
  localparam logic [3:0] LAST_IDX = 4'(NP - 1);
  localparam logic [4:0] LAST_CH  = 5'(CH_N - 1);

  logic [ROWS*COLS*ACC_W-1:0] cap_buf;
  logic                       cap_full;
  logic [NP-1:0][7:0]         send_buf;
  logic [NP-1:0][7:0]         q_val;
  pool_state_t                state, state_nx;
  logic [3:0]                 idx, idx_nx;
  logic [4:0]                 ch;
  logic                       xfer, last_xfer, load;

  // Max before quantize is exact because quantization is monotone.
  for (genvar k = 0; k < NP; k++) begin : g_pool
    logic signed [ACC_W-1:0] e00, e01, e10, e11, m_top, m_bot, m_all;
    assign e00   = cap_buf[(4*k+0)*ACC_W +: ACC_W];
    assign e01   = cap_buf[(4*k+1)*ACC_W +: ACC_W];
    assign e10   = cap_buf[(4*k+2)*ACC_W +: ACC_W];
    assign e11   = cap_buf[(4*k+3)*ACC_W +: ACC_W];
    assign m_top = (e00 > e01) ? e00 : e01;
    assign m_bot = (e10 > e11) ? e10 : e11;
    assign m_all = (m_top > m_bot) ? m_top : m_bot;

    conv2_quant u_quant (
      .acc (m_all),
      .q   (q_val[k])
    );
  end

  assign ready_o   = !cap_full;
  assign ch_o      = ch;
  assign xfer      = (state == S_SEND) && ready_i;
  assign last_xfer = xfer && (idx == LAST_IDX);
  // Loading on the final transfer lets a queued tile follow with no idle cycle.
  assign load      = cap_full && ((state == S_IDLE) || last_xfer);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_nx = S_SEND;
          idx_nx   = '0;
        end
      end
      S_SEND: begin
        if (last_xfer) begin
          state_nx = load ? S_SEND : S_IDLE;
          idx_nx   = '0;
        end else if (xfer) begin
          idx_nx = idx + 4'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
    endcase

    valid_o = (state == S_SEND);
    data_o  = valid_o ? send_buf[idx] : '0;
    row_o   = idx;
    last_o  = valid_o && (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      ch       <= '0;
      cap_full <= 1'b0;
      cap_buf  <= '0;
      send_buf <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (valid_i && !cap_full) begin
        cap_buf  <= data_in;
        cap_full <= 1'b1;
      end else if (load) begin
        cap_full <= 1'b0;
      end
      if (load) begin
        send_buf <= q_val;
      end
      if (last_xfer) begin
        ch <= (ch == LAST_CH) ? '0 : ch + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv2_pool.sv
// tb/tb_conv2_pool.sv - randomized self-checking bench for conv2_pool with a pooling reference model
module tb_conv2_pool;

  localparam int ROWS  = 18;
  localparam int NP    = ROWS / 2;
  localparam int ACC_W = 20;
  localparam int TW    = ROWS * 2 * ACC_W;
  localparam int SHIFT = 8;
  localparam int CH_N  = 32;
`ifdef CONV2_POOL_ROUND_EN
  localparam int RND     = 1 << (SHIFT - 1);
  localparam int EXP_384 = 2;
`else
  localparam int RND     = 0;
  localparam int EXP_384 = 1;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] row;
    logic [4:0] ch;
    logic       last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic [TW-1:0] data_in = '0;
  logic          ready_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [7:0]    data_o;
  logic [3:0]    row_o;
  logic [4:0]    ch_o;
  logic          last_o;

  int    checks = 0;
  int    errors = 0;
  int    exp_ch = 0;
  int    cyc_cnt = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    got_cyc[$];

  conv2_pool #(.ROWS(ROWS), .COLS(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .data_in (data_in),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .row_o   (row_o),
    .ch_o    (ch_o),
    .last_o  (last_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    beat_t b;
    cyc_cnt++;
    if (rst_n && valid_o && ready_i) begin
      b.data = data_o; b.row = row_o; b.ch = ch_o; b.last = last_o;
      got_q.push_back(b);
      got_cyc.push_back(cyc_cnt);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  function automatic int elem(input logic [TW-1:0] t, input int r, input int c);
    logic signed [ACC_W-1:0] v;
    v = t[(2*r+c)*ACC_W +: ACC_W];
    return int'(v);
  endfunction

  function automatic int qref(input int x);
    int y;
    if (x < 0) return 0;
    y = (x + RND) / (1 << SHIFT);
    if (y > 127) return 127;
    return y;
  endfunction

  function automatic logic [TW-1:0] with_elem(input logic [TW-1:0] t, input int r, input int c, input int v);
    logic [TW-1:0] o;
    o = t;
    o[(2*r+c)*ACC_W +: ACC_W] = v[ACC_W-1:0];
    return o;
  endfunction

  function automatic logic [TW-1:0] const_tile(input int v);
    logic [TW-1:0] t;
    t = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 2; c++) t = with_elem(t, r, c, v);
    return t;
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    t = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 2; c++) t = with_elem(t, r, c, int'($urandom_range(0, 60000)) - 20000);
    return t;
  endfunction

  function automatic string fmt(input beat_t b);
    return $sformatf("d=%0d r=%0d ch=%0d l=%0d", b.data, b.row, b.ch, b.last);
  endfunction

  task automatic push_expect(input logic [TW-1:0] t);
    for (int k = 0; k < NP; k++) begin
      int m;
      beat_t b;
      m = elem(t, 2*k, 0);
      for (int j = 1; j < 4; j++)
        if (elem(t, 2*k + j/2, j%2) > m) m = elem(t, 2*k + j/2, j%2);
      b.data = 8'(qref(m)); b.row = 4'(k); b.ch = 5'(exp_ch); b.last = (k == NP - 1);
      exp_q.push_back(b);
    end
    exp_ch = (exp_ch + 1) % CH_N;
  endtask

  task automatic clear_queues();
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_queues();
    exp_ch = 0;
  endtask

  task automatic offer_tile(input logic [TW-1:0] t, output bit acc);
    int c;
    c = 0;
    data_in = t; valid_i = 1'b1;
    while (!ready_o && c < 60) begin @(posedge clk); #1; c++; end
    acc = ready_o;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit to);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin @(posedge clk); #1; c++; end
    to = (got_q.size() < n);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (data_o !== 8'd0)  begin errors++; $display("FAIL reset_data got %0d exp 0", data_o); end
    checks++; if (row_o !== 4'd0)   begin errors++; $display("FAIL reset_row got %0d exp 0", row_o); end
    checks++; if (ch_o !== 5'd0)    begin errors++; $display("FAIL reset_ch got %0d exp 0", ch_o); end
    checks++; if (last_o !== 1'b0)  begin errors++; $display("FAIL reset_last got %b exp 0", last_o); end
  endtask

  task automatic test_basic();
    logic [TW-1:0] t;
    bit to;
    clear_queues();
    t = const_tile(256);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", ready_o); end
    data_in = t; valid_i = 1'b1; push_expect(t);
    @(posedge clk); #1 valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++; $display("FAIL basic_e0 got valid=%b ready=%b exp valid=0 ready=0", valid_o, ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1 || row_o !== 4'd0 || data_o !== 8'd1) begin
      errors++; $display("FAIL basic_e1 got valid=%b row=%0d data=%0d exp 1 0 1", valid_o, row_o, data_o);
    end
    wait_beats(NP, 50, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got %0d beats exp %0d", got_q.size(), NP); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_drop got valid=%b exp 0", valid_o); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %s exp %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_quant();
    logic [TW-1:0] t;
    bit to, acc;
    clear_queues();
    t = rand_tile();
    t = with_elem(t, 0, 0, -5);
    t = with_elem(t, 0, 1, -300);
    t = with_elem(t, 1, 0, 'h7FFFF);
    t = with_elem(t, 1, 1, 10);
    for (int r = 2; r < 4; r++)
      for (int c = 0; c < 2; c++) t = with_elem(t, r, c, -524288);
    offer_tile(t, acc);
    if (acc) push_expect(t);
    wait_beats(NP, 60, to);
    checks++; if (to || !acc) begin errors++; $display("FAIL quant_timeout got %0d beats acc=%b", got_q.size(), acc); end
    checks++; if (got_q.size() > 0 && got_q[0].data !== 8'd127) begin errors++; $display("FAIL quant_sat got %0d exp 127", got_q[0].data); end
    checks++; if (got_q.size() > 1 && got_q[1].data !== 8'd0) begin errors++; $display("FAIL quant_relu got %0d exp 0", got_q[1].data); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL quant_beat%0d got %s exp %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_rounding();
    logic [TW-1:0] t;
    bit to, acc;
    clear_queues();
    t = const_tile(384);
    offer_tile(t, acc);
    if (acc) push_expect(t);
    wait_beats(NP, 60, to);
    checks++; if (to || !acc) begin errors++; $display("FAIL round_timeout got %0d beats acc=%b", got_q.size(), acc); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== 8'(EXP_384)) begin errors++; $display("FAIL round_beat%0d got %0d exp %0d", i, got_q[i].data, EXP_384); end
    end
  endtask

  task automatic test_random();
    bit to;
    int n_acc;
    clear_queues();
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          logic [TW-1:0] t;
          bit acc;
          t = rand_tile();
          offer_tile(t, acc);
          if (acc) begin push_expect(t); n_acc++; end
        end
      end
      begin
        for (int c = 0; c < 120; c++) begin @(posedge clk); #1 ready_i = 1'($urandom_range(0, 1)); end
        ready_i = 1'b1;
      end
    join
    wait_beats(4 * NP, 300, to);
    checks++; if (to || n_acc != 4) begin errors++; $display("FAIL random_timeout got %0d beats %0d tiles exp %0d 4", got_q.size(), n_acc, 4 * NP); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_beat%0d got %s exp %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] ta, tb, tc;
    bit to, acc;
    int c;
    clear_queues();
    ta = rand_tile(); tb = rand_tile(); tc = rand_tile();
    offer_tile(ta, acc);
    if (acc) push_expect(ta);
    c = 0;
    while (!(valid_o && row_o == 4'd3) && c < 30) begin @(posedge clk); #1; c++; end
    checks++; if (c >= 30) begin errors++; $display("FAIL bp_row3_timeout got row=%0d valid=%b", row_o, valid_o); end
    ready_i = 1'b0;
    for (int h = 0; h < 5; h++) begin
      if (h == 0) begin
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_free got %b exp 1", ready_o); end
        data_in = tb; valid_i = 1'b1; push_expect(tb);
      end
      if (h == 2) begin data_in = tc; valid_i = 1'b1; end
      checks++;
      if (valid_o !== 1'b1 || row_o !== 4'd3 || data_o !== exp_q[3].data) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b row=%0d data=%0d exp 1 3 %0d", h, valid_o, row_o, data_o, exp_q[3].data);
      end
      @(posedge clk); #1 valid_i = 1'b0;
      if (h == 0 || h == 2) begin
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low%0d got %b exp 0", h, ready_o); end
      end
    end
    ready_i = 1'b1;
    wait_beats(2 * NP, 80, to);
    repeat (15) @(posedge clk);
    #1;
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %s exp %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int n_acc;
    apply_reset();
    n_acc = 0;
    for (int i = 0; i < 33; i++) begin
      logic [TW-1:0] t;
      bit acc;
      t = rand_tile();
      offer_tile(t, acc);
      if (acc) begin push_expect(t); n_acc++; end
    end
    wait_beats(33 * NP, 400, to);
    checks++; if (to || n_acc != 33) begin errors++; $display("FAIL b2b_count got %0d beats %0d tiles exp %0d 33", got_q.size(), n_acc, 33 * NP); end
    if (got_q.size() >= 33 * NP) begin
      checks++;
      if (got_cyc[33*NP-1] - got_cyc[0] != 33 * NP - 1) begin
        errors++; $display("FAIL b2b_bubble got span %0d exp %0d", got_cyc[33*NP-1] - got_cyc[0], 33 * NP - 1);
      end
      checks++; if (got_q[31*NP].ch !== 5'd31) begin errors++; $display("FAIL b2b_ch31 got %0d exp 31", got_q[31*NP].ch); end
      checks++; if (got_q[32*NP].ch !== 5'd0) begin errors++; $display("FAIL b2b_wrap got %0d exp 0", got_q[32*NP].ch); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got %s exp %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_reset_mid();
    logic [TW-1:0] t;
    bit to, acc;
    int c;
    clear_queues();
    offer_tile(rand_tile(), acc);
    offer_tile(rand_tile(), acc);
    c = 0;
    while (!(valid_o && row_o == 4'd4) && c < 30) begin @(posedge clk); #1; c++; end
    checks++; if (c >= 30) begin errors++; $display("FAIL rmid_row4_timeout got row=%0d valid=%b", row_o, valid_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'd0 || row_o !== 4'd0 || ch_o !== 5'd0 || last_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL rmid_outputs got v=%b d=%0d r=%0d ch=%0d l=%b rdy=%b exp 0 0 0 0 0 1", valid_o, data_o, row_o, ch_o, last_o, ready_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_queues();
    exp_ch = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_discard got valid=%b exp 0", valid_o); end
    t = rand_tile();
    offer_tile(t, acc);
    if (acc) push_expect(t);
    wait_beats(NP, 60, to);
    checks++; if (to || !acc) begin errors++; $display("FAIL rmid_timeout got %0d beats acc=%b", got_q.size(), acc); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d got %s exp %s", i, fmt(got_q[i]), fmt(exp_q[i])); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quant();
    test_rounding();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2_pool.md
# conv2_pool

Post-processing stage directly downstream of `conv2_top`. Accepts one 18×2 tile of signed 20-bit convolution accumulators per `valid_i` pulse and applies ReLU, requantization to 7-bit unsigned activations, and 2×2 max-pooling. It then streams the 9 pooled bytes one per cycle over a ready/valid interface, tagged with output channel and row index. A one-tile capture buffer lets the next `conv2_top` tile arrive while the previous tile is still streaming.

## Interface
- `ROWS`, 18, accumulator rows per tile (even).
- `COLS`, 2, accumulator columns per tile (fixed at 2).
- `ACC_W`, 20, accumulator width, two's complement.
- `SHIFT`, 8, requantization right-shift amount (≥1).
- `CH_N`, 32, output channels per frame.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  tile strobe from `conv2_top`.
- `data_in`  in  ROWS*COLS*ACC_W  tile; element (r,c) at `[(2*r+c)*ACC_W +: ACC_W]`.
- `ready_o`  out  1  capture buffer empty; tile accepted when `valid_i && ready_o`.
- `valid_o`  out  1  pooled byte valid.
- `ready_i`  in  1  downstream ready; byte transfers when `valid_o && ready_i`.
- `data_o`  out  8  pooled activation, range 0..127.
- `row_o`  out  4  pooled row index, 0..ROWS/2-1.
- `ch_o`  out  5  channel index, 0..CH_N-1.
- `last_o`  out  1  high with the final byte of a tile (`row_o` = ROWS/2-1).

## Operation
- Capture: on an accepted tile, register `data_in` and set `cap_full`. `ready_o` = !`cap_full`. A `valid_i` pulse while `ready_o` is low is dropped; no error flag.
- Pool: when `cap_full` is set and the send buffer is free, in one cycle compute for k = 0..ROWS/2-1: `m[k]` = signed max of elements (2k,0),(2k,1),(2k+1,0),(2k+1,1). Load `q(m[k])` into the send buffer and clear `cap_full`.
- Requantization q(x): if x<0 then 0; else y = (x + R) >>> SHIFT, where R is set by the macro in Configuration; saturate y to 127. Compute the x+R addition in ACC_W+1 bits, so there is no overflow. Pooling before quantizing is exact because q is monotone.
- Send buffer is free when state is IDLE, or when state is SEND and the last byte transfers this cycle. A back-to-back tile starts streaming with no bubble.
- FSM states:
  - IDLE: `valid_o`=0.
  - SEND: `valid_o`=1, `row_o` = byte index. The index advances on each transfer. After the transfer at index ROWS/2-1, go to SEND again if a new tile is loaded that cycle, else go to IDLE.
- `ch_o` increments after each tile's last transfer and wraps from CH_N-1 to 0.
- `data_o`, `row_o`, `ch_o` and `last_o` hold stable while `valid_o && !ready_i`.

## Timing
- Reset values: `ready_o`=1, `valid_o`=0, `data_o`=0, `row_o`=0, `ch_o`=0, `last_o`=0. FSM goes to IDLE, `cap_full` clears, `ch_o` counter clears.
- Reset asserted mid-tile discards both buffers. The first tile after release is channel 0.
- Latency: tile accepted at edge E0, pooled at edge E1, `valid_o`=1 with row 0 after E1. With `ready_i` held high, the last byte is at E9 and `valid_o` drops after E10.
- Sustained throughput: one tile per ROWS/2 cycles when `ready_i`=1.
- Simultaneous tile accept and pool load in the same cycle: accept is allowed only when `cap_full`=0, so there is no conflict.

## Configuration
- `CONV2_POOL_ROUND_EN`
  - Defined: R = 1<<(SHIFT-1), round-half-up.
  - Undefined: R = 0, truncation (floor).

## Structure
- Shared package `cnn_pkg` holds `ACC_W`, `SHIFT`, `CH_N`, the FSM state typedef, and the quantized-max constant 127.
- One sub-module, `conv2_quant`: combinational ReLU + round + shift + saturate for one value. It is instantiated ROWS/2 times after the max trees.

## Test plan
- Reset, then one tile with all elements = 0x00100 (256), ready_i=1, SHIFT=8:
  - 9 bytes of value 1, rows 0..8, `last_o` only on row 8, `ch_o`=0.
  - First `valid_o` two cycles after accept.
- Negative and max mix: row pair 0 = {-5, -300, 0x7FFFF, 10}; row pair 1 all = 0x80000:
  - byte0 = 127 (saturated).
  - byte1 = 0 (ReLU).
- Rounding: all elements = 384:
  - With `CONV2_POOL_ROUND_EN`: bytes = 2.
  - Without it: bytes = 1.
- Backpressure: hold `ready_i`=0 for 5 cycles at row 3:
  - Row 3 byte holds stable, then resumes; no byte lost or duplicated.
  - A second tile offered meanwhile is accepted and `ready_o` falls.
  - A third tile offered meanwhile is refused.
- Channel wrap: 33 back-to-back tiles with `ready_i`=1:
  - `ch_o` goes 0..31, 0.
  - 297 contiguous `valid_o` cycles with no bubble.
- Assert `rst_n` low during row 4 of a tile:
  - Outputs go to their reset values immediately.
  - The next tile streams from row 0 with `ch_o`=0.
